// File: rtl/ntt_pkg.sv
// Shared constants, state encoding and helpers for the single-butterfly NTT core.
// Coefficients are kept in [0,Q) everywhere past the input conditioning stage.
package ntt_pkg;

  localparam int unsigned Q          = 3329;
  localparam int unsigned QW         = 12;
  localparam int unsigned BARRETT_M  = 5039;
  localparam int unsigned BARRETT_SH = 24;
  localparam int unsigned ZETA_RST   = 17;

  localparam int unsigned PW     = 2 * QW;
  localparam int unsigned QEW    = 13;
  localparam int unsigned PMW    = PW + QEW;
  localparam int unsigned DOUT_W = 128;
  localparam int unsigned FW     = 16;
  localparam int unsigned CNT_W  = 16;

  localparam int unsigned OFS_U    = 112;
  localparam int unsigned OFS_V    = 96;
  localparam int unsigned OFS_T    = 80;
  localparam int unsigned OFS_A    = 64;
  localparam int unsigned OFS_B    = 48;
  localparam int unsigned OFS_Z    = 32;
  localparam int unsigned OFS_CNT  = 16;
  localparam int unsigned OFS_STAT = 0;

  localparam logic [QW-1:0] Q_C = QW'(Q);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_MUL,
    ST_RED1,
    ST_RED2,
    ST_BFLY
  } state_t;

  // Single conditional subtract: maps the full 12-bit input range onto [0,Q).
  function automatic logic [QW-1:0] cond_sub_q(input logic [QW-1:0] x);
    return (x >= Q_C) ? x - Q_C : x;
  endfunction

  function automatic logic [FW-1:0] zext(input logic [QW-1:0] x);
    return FW'(x);
  endfunction

endpackage

// File: rtl/ntt_barrett_red.sv
// Two-stage Barrett reduction of a 24-bit product into [0,Q).
// Stage 1 estimates the quotient, stage 2 subtracts and applies up to two corrections.
module ntt_barrett_red
  import ntt_pkg::*;
(
  input  logic          clk,
  input  logic          rst,
  input  logic          i_en,
  input  logic [PW-1:0] i_p,
  output logic [QW-1:0] o_t
);

  logic [PMW-1:0] w_prod;
  logic [QEW-1:0] w_qe;
  logic [PW-1:0]  w_r0;
  logic [PW-1:0]  w_r1;
  logic [PW-1:0]  w_r2;

  logic [PW-1:0]  r_p;
  logic [QEW-1:0] r_qe;
  logic [QW-1:0]  r_t;

  assign w_prod = PMW'(i_p) * PMW'(BARRETT_M);
  assign w_qe   = QEW'(w_prod >> BARRETT_SH);

  // The quotient estimate never exceeds the true quotient, so w_r0 is non-negative.
  assign w_r0 = r_p - PW'(r_qe) * PW'(Q);
  assign w_r1 = (w_r0 >= PW'(Q)) ? w_r0 - PW'(Q) : w_r0;
  assign w_r2 = (w_r1 >= PW'(Q)) ? w_r1 - PW'(Q) : w_r1;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_p  <= '0;
      r_qe <= '0;
      r_t  <= '0;
    end else if (i_en) begin
      r_p  <= i_p;
      r_qe <= w_qe;
      r_t  <= QW'(w_r2);
    end
  end

  assign o_t = r_t;

endmodule

// File: rtl/ntt_bfly_core.sv
// Single Cooley-Tukey butterfly mod Q behind the blk_* local-bus handshake.
// One op every 5 enabled cycles; result packed into a 128-bit word.
module ntt_bfly_core
  import ntt_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic [QW-1:0]     a,
  input  logic [QW-1:0]     b,
  input  logic              blk_krdy,
  input  logic              blk_drdy,
  input  logic              blk_en,
  input  logic              blk_rstn,
  output logic              blk_kvld,
  output logic              blk_dvld,
  output logic [DOUT_W-1:0] blk_dout,
  output logic              busy
);

  state_t r_state;
  state_t w_state_nxt;

  logic              w_srst;
  logic              w_accept;
  logic              w_overrun;
  logic              w_range;
  logic [QW-1:0]     w_a_cond;
  logic [QW-1:0]     w_b_cond;
  logic [QW-1:0]     w_t;
  logic [QW:0]       w_sum;
  logic [QW-1:0]     w_u;
  logic [QW-1:0]     w_v;
  logic [DOUT_W-1:0] w_dout_nxt;

  logic [QW-1:0]     r_zeta;
  logic [QW-1:0]     r_a;
  logic [QW-1:0]     r_b;
  logic [QW-1:0]     r_z;
  logic [PW-1:0]     r_p;
  logic [1:0]        r_status;
  logic [CNT_W-1:0]  r_op_cnt;
  logic              r_kvld;
  logic              r_dvld;
  logic              r_busy;
  logic [DOUT_W-1:0] r_dout;

  assign w_srst = rst | ~blk_rstn;

  always_ff @(posedge clk) begin
    if (w_srst) begin
      r_state <= ST_IDLE;
    end else if (blk_en) begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_accept    = 1'b0;
    w_overrun   = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (blk_drdy) begin
          w_accept    = 1'b1;
          w_state_nxt = ST_MUL;
        end
      end
      ST_MUL:  w_state_nxt = ST_RED1;
      ST_RED1: w_state_nxt = ST_RED2;
      ST_RED2: w_state_nxt = ST_BFLY;
      ST_BFLY: w_state_nxt = ST_IDLE;
      default: w_state_nxt = ST_IDLE;
    endcase
    if (r_state != ST_IDLE && blk_drdy) begin
      w_overrun = 1'b1;
    end
  end

  assign w_a_cond = cond_sub_q(a);
  assign w_b_cond = cond_sub_q(b);
  assign w_range  = (a >= Q_C) | (b >= Q_C);

  ntt_barrett_red u_red (
    .clk  (clk),
    .rst  (w_srst),
    .i_en (blk_en),
    .i_p  (r_p),
    .o_t  (w_t)
  );

  assign w_sum = {1'b0, r_a} + {1'b0, w_t};
  assign w_u   = (w_sum >= {1'b0, Q_C}) ? QW'(w_sum - {1'b0, Q_C}) : QW'(w_sum);
  // Wraps through 12 bits on the negative branch; the final value is always in [0,Q).
  assign w_v   = (r_a >= w_t) ? r_a - w_t : r_a + Q_C - w_t;

  // An overrun arriving in the BFLY cycle still belongs to the op being reported.
  always_comb begin
    w_dout_nxt                    = '0;
    w_dout_nxt[OFS_U +: FW]       = zext(w_u);
    w_dout_nxt[OFS_V +: FW]       = zext(w_v);
    w_dout_nxt[OFS_T +: FW]       = zext(w_t);
    w_dout_nxt[OFS_A +: FW]       = zext(r_a);
    w_dout_nxt[OFS_B +: FW]       = zext(r_b);
    w_dout_nxt[OFS_Z +: FW]       = zext(r_z);
    w_dout_nxt[OFS_CNT +: FW]     = r_op_cnt + CNT_W'(1);
    w_dout_nxt[OFS_STAT +: FW]    = {14'b0, r_status[1] | w_overrun, r_status[0]};
  end

  always_ff @(posedge clk) begin
    if (w_srst) begin
      r_zeta   <= QW'(ZETA_RST);
      r_a      <= '0;
      r_b      <= '0;
      r_z      <= '0;
      r_p      <= '0;
      r_status <= '0;
      r_op_cnt <= '0;
      r_kvld   <= 1'b0;
      r_dvld   <= 1'b0;
      r_busy   <= 1'b0;
      r_dout   <= '0;
    end else if (blk_en) begin
      r_kvld <= blk_krdy;
      r_dvld <= (r_state == ST_BFLY);
      r_busy <= (w_state_nxt != ST_IDLE);
      if (blk_krdy) begin
        r_zeta <= w_b_cond;
      end
      if (w_accept) begin
        r_a      <= w_a_cond;
        r_b      <= w_b_cond;
        r_z      <= blk_krdy ? w_b_cond : r_zeta;
        r_status <= {1'b0, w_range};
      end else if (w_overrun) begin
        r_status[1] <= 1'b1;
      end
      if (r_state == ST_MUL) begin
        r_p <= PW'(r_z) * PW'(r_b);
      end
      if (r_state == ST_BFLY) begin
        r_dout   <= w_dout_nxt;
        r_op_cnt <= r_op_cnt + CNT_W'(1);
      end
    end
  end

  assign blk_kvld = r_kvld;
  assign blk_dvld = r_dvld;
  assign blk_dout = r_dout;
  assign busy     = r_busy;

endmodule

// File: tb/tb_ntt_bfly_core.sv
// Directed and random checks of ntt_bfly_core against a plain mod-Q reference model.
module tb_ntt_bfly_core;

  logic         clk;
  logic         rst;
  logic [11:0]  a;
  logic [11:0]  b;
  logic         blk_krdy;
  logic         blk_drdy;
  logic         blk_en;
  logic         blk_rstn;
  logic         blk_kvld;
  logic         blk_dvld;
  logic [127:0] blk_dout;
  logic         busy;

  int vectors;
  int fails;
  int exp_cnt;
  int cur_z;
  int seen;

  ntt_bfly_core dut (
    .clk      (clk),
    .rst      (rst),
    .a        (a),
    .b        (b),
    .blk_krdy (blk_krdy),
    .blk_drdy (blk_drdy),
    .blk_en   (blk_en),
    .blk_rstn (blk_rstn),
    .blk_kvld (blk_kvld),
    .blk_dvld (blk_dvld),
    .blk_dout (blk_dout),
    .busy     (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [127:0] model(input int aa, input int bb, input int zz,
                                         input int cnt, input int stat);
    int ar, br, zr, t, u, v;
    ar = (aa >= 3329) ? aa - 3329 : aa;
    br = (bb >= 3329) ? bb - 3329 : bb;
    zr = (zz >= 3329) ? zz - 3329 : zz;
    t  = (zr * br) % 3329;
    u  = (ar + t) % 3329;
    v  = (ar - t + 3329) % 3329;
    return {16'(u), 16'(v), 16'(t), 16'(ar), 16'(br), 16'(zr), 16'(cnt), 16'(stat)};
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    vectors++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic load_zeta(input string tag, input int z);
    b        = 12'(z);
    blk_krdy = 1'b1;
    step();
    blk_krdy = 1'b0;
    chk({tag, "_kvld1"}, 128'(blk_kvld), 128'(1));
    step();
    chk({tag, "_kvld0"}, 128'(blk_kvld), 128'(0));
    cur_z = z;
  endtask

  task automatic start(input int aa, input int bb);
    a        = 12'(aa);
    b        = 12'(bb);
    blk_drdy = 1'b1;
    step();
    blk_drdy = 1'b0;
  endtask

  task automatic wait_dvld(input string tag);
    int n;
    n = 1;
    while (blk_dvld !== 1'b1 && n < 20) begin
      step();
      n++;
    end
    chk({tag, "_lat"}, 128'(n), 128'(5));
  endtask

  task automatic do_op(input string tag, input int aa, input int bb, input int stat);
    start(aa, bb);
    wait_dvld(tag);
    exp_cnt = (exp_cnt + 1) & 16'hFFFF;
    chk(tag, blk_dout, model(aa, bb, cur_z, exp_cnt, stat));
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    vectors  = 0;
    fails    = 0;
    exp_cnt  = 0;
    cur_z    = 17;
    rst      = 1'b1;
    a        = '0;
    b        = '0;
    blk_krdy = 1'b0;
    blk_drdy = 1'b0;
    blk_en   = 1'b1;
    blk_rstn = 1'b1;
    step();
    step();
    rst = 1'b0;

    // Reset state, then an op with the reset zeta.
    chk("rst_dout", blk_dout, 128'(0));
    chk("rst_flags", 128'({blk_dvld, blk_kvld, busy}), 128'(0));
    do_op("rst_zeta", 1, 1, 0);

    // Basic op with explicit zeta load.
    load_zeta("ld17", 17);
    start(1, 1);
    chk("busy_hi", 128'(busy), 128'(1));
    wait_dvld("basic");
    exp_cnt++;
    chk("basic", blk_dout, {16'd18, 16'd3313, 16'd17, 16'd1, 16'd1, 16'd17, 16'(exp_cnt), 16'd0});
    step();
    chk("dvld_1wide", 128'(blk_dvld), 128'(0));

    // Extreme values: 3328 = -1 mod Q.
    load_zeta("ld3328", 3328);
    start(3328, 3328);
    wait_dvld("max");
    exp_cnt++;
    chk("max", blk_dout, {16'd0, 16'd3327, 16'd1, 16'd3328, 16'd3328, 16'd3328, 16'(exp_cnt), 16'd0});

    // Out-of-range operand.
    load_zeta("ld17b", 17);
    start(4095, 0);
    wait_dvld("range");
    exp_cnt++;
    chk("range", blk_dout, {16'd766, 16'd766, 16'd0, 16'd766, 16'd0, 16'd17, 16'(exp_cnt), 16'd1});

    // Overrun: drdy at T and T+2, then back-to-back accept at T+5.
    a = 12'd5; b = 12'd7; blk_drdy = 1'b1;
    step();
    blk_drdy = 1'b0;
    step();
    a = 12'd9; b = 12'd9; blk_drdy = 1'b1;
    step();
    blk_drdy = 1'b0;
    step();
    chk("ovr_no_early", 128'(blk_dvld), 128'(0));
    step();
    chk("ovr_dvld", 128'(blk_dvld), 128'(1));
    exp_cnt++;
    chk("ovr", blk_dout, model(5, 7, cur_z, exp_cnt, 2));
    do_op("after_ovr", 11, 13, 0);

    // Enable low: FSM frozen and a krdy in the frozen window is lost.
    start(6, 7);
    blk_en   = 1'b0;
    b        = 12'd999;
    blk_krdy = 1'b1;
    step();
    blk_krdy = 1'b0;
    step();
    step();
    chk("en_frozen", 128'({busy, blk_dvld}), 128'(2'b10));
    blk_en = 1'b1;
    wait_dvld("en");
    exp_cnt++;
    chk("en", blk_dout, model(6, 7, cur_z, exp_cnt, 0));
    chk("en_kvld", 128'(blk_kvld), 128'(0));

    // krdy and drdy together: the fresh zeta (=b) is used.
    a = 12'd10; b = 12'd4000; blk_krdy = 1'b1; blk_drdy = 1'b1;
    step();
    blk_krdy = 1'b0; blk_drdy = 1'b0;
    cur_z = 4000;
    wait_dvld("kd");
    exp_cnt++;
    chk("kd", blk_dout, model(10, 4000, 4000, exp_cnt, 1));

    // Soft reset mid-op aborts it.
    load_zeta("ld100", 100);
    start(20, 30);
    step();
    step();
    blk_rstn = 1'b0;
    step();
    blk_rstn = 1'b1;
    chk("srst_flags", 128'({busy, blk_dvld, blk_kvld}), 128'(0));
    chk("srst_dout", blk_dout, 128'(0));
    seen = 0;
    for (int i = 0; i < 8; i++) begin
      step();
      if (blk_dvld) seen++;
    end
    chk("srst_no_dvld", 128'(seen), 128'(0));
    cur_z   = 17;
    exp_cnt = 0;
    do_op("srst_after", 2, 3, 0);

    // Counter wrap.
    force dut.r_op_cnt = 16'hFFFF;
    #1;
    release dut.r_op_cnt;
    exp_cnt = 16'hFFFF;
    do_op("wrap", 4, 5, 0);
    chk("wrap_cnt", 128'(blk_dout[31:16]), 128'(0));

    // Random scoreboard.
    for (int i = 0; i < 24; i++) begin
      int ra, rb, rz;
      rz = int'($urandom_range(0, 4095));
      ra = int'($urandom_range(0, 4095));
      rb = int'($urandom_range(0, 4095));
      load_zeta("rnd_ld", rz);
      do_op("rnd", ra, rb, ((ra >= 3329) || (rb >= 3329)) ? 1 : 0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, fails);
    $finish;
  end

endmodule
